// File: rtl/uart_tx_seq.sv
// UART transmit sequencer: serialises one DATA word per VALID/READY handshake as
// start, LSB-first data, optional parity and stop bits, timed by an oversampled TICK.
module uart_tx_seq #(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TICK,
   input  logic [DATA_W-1:0] DATA,
   input  logic              VALID,
   output logic              READY,
   output logic              TX,
   output logic              BUSY
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_W);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_reg;
   logic [TICK_W-1:0] tick_cnt_reg;
   logic [BIT_W-1:0]  bit_cnt_reg;
   logic [DATA_W-1:0] shift_reg;
   logic              parity_reg;
   logic              tx_reg;
   logic              ready_reg;
   logic              busy_reg;
   logic              bit_end;

   // The bit in flight ends on the TICK that completes OVERSAMPLE ticks.
   assign bit_end = TICK && (tick_cnt_reg == TICK_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= S_IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         tx_reg       <= 1'b1;
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         if (state_reg != S_IDLE && TICK) begin
            tick_cnt_reg <= bit_end ? '0 : tick_cnt_reg + TICK_W'(1);
         end

         case (state_reg)
            S_IDLE: begin
               tick_cnt_reg <= '0;
               if (VALID) begin
                  // Odd parity is the inverted even parity of the latched word.
                  shift_reg   <= DATA;
                  parity_reg  <= (^DATA) ^ (PARITY == 2);
                  bit_cnt_reg <= '0;
                  tx_reg      <= 1'b0;
                  ready_reg   <= 1'b0;
                  busy_reg    <= 1'b1;
                  state_reg   <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_cnt_reg <= '0;
                  state_reg   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_cnt_reg == DATA_LAST) begin
                     bit_cnt_reg <= '0;
                     if (PARITY != 0) begin
                        tx_reg    <= parity_reg;
                        state_reg <= S_PARITY;
                     end else begin
                        tx_reg    <= 1'b1;
                        state_reg <= S_STOP;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  tx_reg      <= 1'b1;
                  bit_cnt_reg <= '0;
                  state_reg   <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (bit_cnt_reg == STOP_LAST) begin
                     bit_cnt_reg <= '0;
                     ready_reg   <= 1'b1;
                     busy_reg    <= 1'b0;
                     state_reg   <= S_IDLE;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                  end
               end
            end
            default: begin
               tx_reg    <= 1'b1;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign READY = ready_reg;
   assign BUSY  = busy_reg;
   assign TX    = tx_reg;

endmodule
